wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/y86_pkg.sv | 17 +
 rtl/wb_dst_decode.sv | 23 ++
 rtl/wb_regfile.sv | 84 ++++++++
 tb/tb_wb_regfile.sv | 135 +++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: Y86 instruction codes and register indices shared by the write-back stage
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;
endpackage

// File: rtl/wb_dst_decode.sv
// wb_dst_decode: combinational dstE/dstM decode from icode, register specifiers and cnd
module wb_dst_decode
  import y86_pkg::*;
#(
  parameter int RID_W = 4
) (
  input  logic [3:0]       icode,
  input  logic [RID_W-1:0] r_a,
  input  logic [RID_W-1:0] r_b,
  input  logic             cnd,
  output logic [RID_W-1:0] dst_e,
  output logic [RID_W-1:0] dst_m
);
  localparam logic [RID_W-1:0] NONE = RID_W'(REG_NONE);
  localparam logic [RID_W-1:0] RSP  = RID_W'(REG_RSP);
  // destinations; conditional moves that fail write nowhere
  always_comb begin
    dst_e = (icode == IRRMOVQ) ? (cnd ? r_b : NONE) :
            (icode == IIRMOVQ || icode == IOPQ) ? r_b :
            (icode == ICALL || icode == IRET || icode == IPUSHQ || icode == IPOPQ) ? RSP : NONE;
    dst_m = (icode == IMRMOVQ || icode == IPOPQ) ? r_a : NONE;
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: Y86 write-back register file; define WB_BYPASS_EN for same-cycle read bypass
module wb_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int RID_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [3:0]        icode,
  input  logic [RID_W-1:0]  rA,
  input  logic [RID_W-1:0]  rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [RID_W-1:0]  srcA,
  input  logic [RID_W-1:0]  srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [RID_W-1:0]  dstE,
  output logic [RID_W-1:0]  dstM,
  output logic              wb_done,
  output logic              ins_err
);
  localparam logic [RID_W-1:0] NONE = RID_W'(REG_NONE);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wb_done_q, wb_done_d, ins_err_q, ins_err_d;
  logic              bad, we_e, we_m;
  logic [DATA_W-1:0] rd_a, rd_b;
  wb_dst_decode #(.RID_W(RID_W)) u_dec (
    .icode(icode),
    .r_a  (rA),
    .r_b  (rB),
    .cnd  (cnd),
    .dst_e(dstE),
    .dst_m(dstM)
  );
  // commit enables; popq %rsp lets valM win over valE, reset drops the write
  always_comb begin
    bad  = icode > IPOPQ;
    we_m = wb_valid && !rst && !bad && dstM != NONE && int'(dstM) < NREGS;
    we_e = wb_valid && !rst && !bad && dstE != NONE && int'(dstE) < NREGS && !(we_m && dstE == dstM);
  end
  // next register contents and status flags
  always_comb begin
    for (int i = 0; i < NREGS; i++)
      regs_d[i] = (we_m && dstM == RID_W'(i)) ? valM : (we_e && dstE == RID_W'(i)) ? valE : regs_q[i];
    wb_done_d = we_e || we_m;
    ins_err_d = ins_err_q || (wb_valid && bad);
  end
  // state update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wb_done_q <= 1'b0;
      ins_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      wb_done_q <= wb_done_d;
      ins_err_q <= ins_err_d;
    end
  end
  // read ports; out-of-range and none indices return zero
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      rd_a = (srcA == RID_W'(i)) ? regs_q[i] : rd_a;
      rd_b = (srcB == RID_W'(i)) ? regs_q[i] : rd_b;
    end
`ifdef WB_BYPASS_EN
    valA = (we_m && srcA == dstM) ? valM : (we_e && srcA == dstE) ? valE : rd_a;
    valB = (we_m && srcB == dstM) ? valM : (we_e && srcB == dstE) ? valE : rd_b;
`else
    valA = rd_a;
    valB = rd_b;
`endif
  end
  assign wb_done = wb_done_q;
  assign ins_err = ins_err_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of decode, write-back, flags, reset and bypass
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst, wb_valid, cnd;
  logic [3:0]  icode, r_a, r_b, src_a, src_b, dst_e, dst_m;
  logic [63:0] val_e, val_m, val_a, val_b;
  logic        wb_done, ins_err;
  int          n_tests = 0;
  int          n_fail = 0;
  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(r_a), .rB(r_b),
    .cnd(cnd), .valE(val_e), .valM(val_m), .srcA(src_a), .srcB(src_b),
    .valA(val_a), .valB(val_b), .dstE(dst_e), .dstM(dst_m),
    .wb_done(wb_done), .ins_err(ins_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wb(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                    input logic c, input logic [63:0] ve, input logic [63:0] vm);
    wb_valid = 1'b1; icode = ic; r_a = ra; r_b = rb; cnd = c; val_e = ve; val_m = vm;
  endtask
  initial begin
    rst = 1'b1; wb_valid = 1'b0; icode = 4'h1; r_a = 4'hF; r_b = 4'hF; cnd = 1'b0;
    val_e = '0; val_m = '0; src_a = 4'h0; src_b = 4'hE;
    step(); step();
    rst = 1'b0;
    chk("rst_wb_done", wb_done, 0);
    chk("rst_ins_err", ins_err, 0);
    chk("rst_valA", val_a, 0);
    chk("rst_valB", val_b, 0);
    wb(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0);
    #1;
    chk("irmov_dstE", dst_e, 4'h2);
    chk("irmov_dstM", dst_m, 4'hF);
    step();
    wb_valid = 1'b0; src_a = 4'h2;
    #1;
    chk("irmov_valA", val_a, 64'h1234);
    chk("irmov_done", wb_done, 1);
    step();
    chk("irmov_done_drop", wb_done, 0);
    wb(4'h2, 4'hF, 4'h3, 1'b0, 64'h55, 64'h0);
    src_b = 4'h3;
    #1;
    chk("cmov_nc_dstE", dst_e, 4'hF);
    step();
    wb_valid = 1'b0;
    chk("cmov_nc_reg3", val_b, 0);
    chk("cmov_nc_done", wb_done, 0);
    wb(4'h2, 4'hF, 4'h3, 1'b1, 64'h66, 64'h0);
    #1;
    chk("cmov_c_dstE", dst_e, 4'h3);
    step();
    wb_valid = 1'b0;
    chk("cmov_c_reg3", val_b, 64'h66);
    wb(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h200);
    src_a = 4'h4;
    #1;
    chk("popq_dstE", dst_e, 4'h4);
    chk("popq_dstM", dst_m, 4'h4);
    step();
    wb_valid = 1'b0;
    chk("popq_rsp_reg4", val_a, 64'h200);
    chk("popq_done", wb_done, 1);
    wb(4'hA, 4'h6, 4'hF, 1'b0, 64'hF8, 64'h0);
    #1;
    chk("push_dstM", dst_m, 4'hF);
    step();
    chk("push_reg4", val_a, 64'hF8);
    wb(4'h5, 4'h6, 4'h1, 1'b0, 64'h999, 64'hABCD);
    src_a = 4'h6; src_b = 4'h1;
    step();
    wb_valid = 1'b0;
    chk("mrmov_reg6", val_a, 64'hABCD);
    chk("mrmov_reg1", val_b, 0);
    icode = 4'h3; r_b = 4'h7; val_e = 64'h77; src_a = 4'h7;
    step();
    chk("idle_reg7", val_a, 0);
    chk("idle_done", wb_done, 0);
    wb(4'h3, 4'hF, 4'hE, 1'b0, 64'hEE, 64'h0);
    src_b = 4'hE;
    step();
    wb_valid = 1'b0;
    chk("last_reg14", val_b, 64'hEE);
    src_a = 4'hF;
    #1;
    chk("none_read", val_a, 0);
    wb(4'h3, 4'hF, 4'h5, 1'b0, 64'h3, 64'h0);
    src_b = 4'h5;
    step();
    chk("b2b_done1", wb_done, 1);
    wb(4'h6, 4'hF, 4'h5, 1'b0, 64'h9, 64'h0);
    #1;
`ifdef WB_BYPASS_EN
    chk("opq_bypass_valB", val_b, 64'h9);
`else
    chk("opq_nobypass_valB", val_b, 64'h3);
`endif
    step();
    wb_valid = 1'b0;
    chk("opq_reg5", val_b, 64'h9);
    chk("b2b_done2", wb_done, 1);
    wb(4'hD, 4'h2, 4'h2, 1'b1, 64'hDEAD, 64'hBEEF);
    src_a = 4'h2;
    step();
    wb_valid = 1'b0;
    chk("bad_ins_err", ins_err, 1);
    chk("bad_done", wb_done, 0);
    chk("bad_reg2", val_a, 64'h1234);
    step(); step();
    chk("bad_sticky", ins_err, 1);
    rst = 1'b1;
    wb(4'h6, 4'hF, 4'h1, 1'b0, 64'h7, 64'h0);
    src_a = 4'h1; src_b = 4'h2;
    step();
    rst = 1'b0; wb_valid = 1'b0;
    #1;
    chk("rstwr_reg1", val_a, 0);
    chk("rstwr_reg2", val_b, 0);
    chk("rstwr_ins_err", ins_err, 0);
    chk("rstwr_done", wb_done, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
